// File: rtl/me_pkg.sv
// Shared motion-estimation constants and types.
// Used by the reference memory and its row feeder.
package me_pkg;

    localparam int PIXEL   = 8;
    localparam int X       = 32;
    localparam int BUS_PIX = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
    } feeder_state_t;

endpackage

// File: rtl/row_assembler.sv
// Packs frame-buffer beats into one reference row.
// Beat n lands at the n-th slot from the MSB end.
import me_pkg::*;

module row_assembler #(
    parameter int PIXEL   = me_pkg::PIXEL,
    parameter int X       = me_pkg::X,
    parameter int BUS_PIX = me_pkg::BUS_PIX
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [BUS_PIX*PIXEL-1:0]   wr_data,
    output logic [X*PIXEL-1:0]         row,
    output logic                       full
);

    localparam int BEATS = X / BUS_PIX;
    localparam int CW    = $clog2(BEATS + 1);
    localparam int BW    = BUS_PIX * PIXEL;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      idx;
    logic [X*PIXEL-1:0] row_q, row_d;

    // A clear restarts at beat 0; a beat in the same cycle becomes beat 0.
    always_comb begin
        cnt_d = cnt_q;
        row_d = row_q;
        idx   = clr ? '0 : cnt_q;
        if (clr) begin
            cnt_d = '0;
        end
        if (wr_en && (idx < CW'(BEATS))) begin
            for (int b = 0; b < BEATS; b++) begin
                if (idx == CW'(b)) begin
                    row_d[(X-b*BUS_PIX)*PIXEL-1 -: BW] = wr_data;
                end
            end
            cnt_d = idx + CW'(1);
        end
    end

    // Fill counter and pack register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

    assign row  = row_q;
    assign full = (cnt_q == CW'(BEATS));

endmodule

// File: rtl/ref_row_feeder.sv
// Streams a search window from the frame buffer
// into the reference memory, one packed row per strobe.
import me_pkg::*;

module ref_row_feeder #(
    parameter int PIXEL   = me_pkg::PIXEL,
    parameter int X       = me_pkg::X,
    parameter int BUS_PIX = me_pkg::BUS_PIX,
    parameter int ROWS    = 64,
    parameter int ADDR_W  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W-1:0]        stride,
    input  logic                     hold,
    output logic                     mem_req_valid,
    output logic [ADDR_W-1:0]        mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [BUS_PIX*PIXEL-1:0] mem_rsp_data,
    output logic [X*PIXEL-1:0]       ref_input,
    output logic                     beg_en,
    output logic                     busy,
    output logic                     done
);

    localparam int BEATS = X / BUS_PIX;
    localparam int QCW   = $clog2(BEATS + 1);
    localparam int RCW   = $clog2(ROWS + 1);

    feeder_state_t      state_q, state_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [ADDR_W-1:0]  stride_q, stride_d;
    logic [RCW-1:0]     row_cnt_q, row_cnt_d;
    logic [QCW-1:0]     req_cnt_q, req_cnt_d;
    logic [X*PIXEL-1:0] ref_q, ref_d;
    logic               beg_q, beg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               in_fetch;
    logic               req_hs;
    logic               row_wr;
    logic               asm_clr;
    logic               asm_full;
    logic [X*PIXEL-1:0] asm_row;

    // Request port decodes straight from the counters so it holds under stall.
    always_comb begin
        in_fetch      = (state_q == FETCH);
        mem_req_valid = in_fetch
                      && (req_cnt_q < QCW'(BEATS))
                      && (row_cnt_q < RCW'(ROWS));
        mem_req_addr  = '0;
        if (in_fetch) begin
            mem_req_addr = row_base_q
                         + ADDR_W'(req_cnt_q) * ADDR_W'(BUS_PIX);
        end
        req_hs  = mem_req_valid && mem_req_ready;
        row_wr  = in_fetch && asm_full && !hold;
        asm_clr = row_wr || !in_fetch;
    end

    row_assembler #(
        .PIXEL   (PIXEL),
        .X       (X),
        .BUS_PIX (BUS_PIX)
    ) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (asm_clr),
        .wr_en   (in_fetch && mem_rsp_valid),
        .wr_data (mem_rsp_data),
        .row     (asm_row),
        .full    (asm_full)
    );

    // Window sequencing: launch, per-row write, final flush.
    always_comb begin
        state_d    = state_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;
        row_cnt_d  = row_cnt_q;
        req_cnt_d  = req_cnt_q;
        ref_d      = ref_q;
        beg_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    row_base_d = base_addr;
                    stride_d   = stride;
                    row_cnt_d  = '0;
                    req_cnt_d  = '0;
                    busy_d     = 1'b1;
                end
            end
            FETCH: begin
                if (req_hs) begin
                    req_cnt_d = req_cnt_q + QCW'(1);
                end
                if (row_wr) begin
                    ref_d      = asm_row;
                    beg_d      = 1'b1;
                    req_cnt_d  = '0;
                    row_cnt_d  = row_cnt_q + RCW'(1);
                    row_base_d = row_base_q + stride_q;
                    if (row_cnt_q == RCW'(ROWS - 1)) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            row_base_q <= '0;
            stride_q   <= '0;
            row_cnt_q  <= '0;
            req_cnt_q  <= '0;
            ref_q      <= '0;
            beg_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_base_q <= row_base_d;
            stride_q   <= stride_d;
            row_cnt_q  <= row_cnt_d;
            req_cnt_q  <= req_cnt_d;
            ref_q      <= ref_d;
            beg_q      <= beg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ref_input = ref_q;
    assign beg_en    = beg_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
